vga_pic_gen: RTL and testbench
==============================

# vga_pic_gen

Test-pattern pixel source that feeds the VGA timing controller. It consumes the controller's request coordinates (`pix_x`, `pix_y`, 10'h3FF when idle) and returns registered 12-bit RGB444 `pix_data` one clock later, aligned with the controller's valid display window. It offers three selectable patterns: colour bars, a bouncing square and a gradient. Pattern changes and motion updates take effect only at frame boundaries.

## Interface
- `H_VALID`, 640: active pixels per line.
- `V_VALID`, 480: active lines per frame.
- `SQ_SIZE`, 40: square edge length in pixels.
- `SQ_STEP`, 2: square displacement per frame, per axis, in pixels.
- `vga_clk`  in  1  pixel clock, 25 MHz; the only clock.
- `sys_rst_n`  in  1  reset; synchronous and active-low.
- `pix_x`  in  10  requested X coordinate; 10'h3FF = no request.
- `pix_y`  in  10  requested Y coordinate; 10'h3FF = no request.
- `mode_next`  in  1  single-cycle pulse that requests the next pattern.
- `pix_data`  out  12  RGB444 colour {R[3:0],G[3:0],B[3:0]}, registered.
- `mode`  out  2  active pattern: 0 = BARS, 1 = SQUARE, 2 = GRAD.
- `frame_tick`  out  1  one-cycle pulse after the last active pixel request.

## Operation
- **Request.** A request is valid when `pix_x != 10'h3FF` and `pix_y != 10'h3FF`. Otherwise next-cycle `pix_data` = 12'h000.
- **End of frame.** `eof` = valid request with `pix_x == H_VALID-1` and `pix_y == V_VALID-1`.
- **Mode FSM.** States BARS → SQUARE → GRAD → BARS.
  - A `mode_next` pulse sets a `pending` flag. Further pulses before `eof` do not add more steps.
  - On an `eof` edge with `pending`, or with `mode_next` high in that same cycle: advance one state and clear `pending`.
  - Unused encoding 3: next state BARS.
- **BARS.** 8 vertical bars, each H_VALID/8 = 80 px wide. Left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- **GRAD.** {`pix_x[9:6]`, `pix_y[8:5]`, 4'h0}.
- **SQUARE.**
  - Colour F00 where `sq_x <= pix_x < sq_x+SQ_SIZE` and `sq_y <= pix_y < sq_y+SQ_SIZE`; background 00F.
  - Compares use 11-bit arithmetic so the `+SQ_SIZE` sum cannot overflow.
- **Motion.** Updated on every `eof` edge, in every mode, so motion continues while hidden.
  - X axis: `sq_x` moves by ±SQ_STEP. If the result would pass 0 or H_VALID-SQ_SIZE (600), it clamps to that limit and `dir_x` toggles. Same cycle, no overshoot.
  - Y axis: same rule, limit V_VALID-SQ_SIZE (440).

## Timing
- `pix_data` latency is 1 cycle: a request at edge N gives a colour after edge N+1. This matches the controller issuing requests one cycle ahead of its valid window.
- `frame_tick` is high for exactly the cycle after the `eof` request.
- Mode and square position change on the edge that samples `eof`. The new values apply to the first request of the next frame. Within a frame the pattern never changes.
- Reset state while `sys_rst_n` = 0 at a clock edge:
  - `pix_data` = 0, `frame_tick` = 0, `mode` = BARS, `pending` = 0.
  - `sq_x` = `sq_y` = 0, `dir_x` = `dir_y` = +.
- Reset mid-frame: outputs reach reset values on that edge. Output resumes on the first request after release, with no stale pending mode change.
- `mode_next` is ignored while in reset.

## Configuration
- `VGA_PIC_BORDER_EN` defined: any valid request with `pix_x` ∈ {0, H_VALID-1} or `pix_y` ∈ {0, V_VALID-1} outputs FFF, in every mode. This overrides the pattern and is used for monitor alignment.
- `VGA_PIC_BORDER_EN` undefined: no border logic is built; edge pixels show the pattern colour.

## Structure
- Package `vga_pic_pkg` holds:
  - mode encoding constants MODE_BARS / MODE_SQUARE / MODE_GRAD;
  - RGB444 colour constants (WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK);
  - the 10'h3FF no-request constant.
- Sub-module `vga_square_mover`: one instance that holds `sq_x`, `sq_y`, `dir_x`, `dir_y` and the clamp/reflect logic. Inputs are the clock, reset and `eof`; outputs are `sq_x` and `sq_y`.
- The top level holds the mode FSM, the colour mux and the output register.

## Test plan
- **Bars.** Reset, then request (0,0), (80,0), (639,479) → `pix_data` = FFF, FF0, 000 one cycle later. With BORDER_EN, (639,479) → FFF.
- **Idle request.** `pix_x` = 3FF, `pix_y` = 10 → `pix_data` = 000. Full 800x525 frame → exactly one `frame_tick`, one cycle after (639,479).
- **Mode change.** Pulse `mode_next` mid-frame → `mode` stays 0 until `eof`, then 1. Three pulses in one frame → advances only one step. Pulse coincident with `eof` → advances at that edge.
- **Square motion.** SQUARE mode, frame 0: (0,0) → F00, (40,0) → 00F. After 300 frames `sq_x` = 600. The next frame gives `sq_x` = 598 with `dir_x` reversed. `sq_y` reflects at 440 after 220 frames.
- **Gradient.** GRAD mode: (64,32) → 0x110; (639,479) → 0x9E0.
- **Reset mid-frame.** Assert `sys_rst_n` = 0 for one edge mid-frame, with `pending` set and `sq_x` = 100 → `mode` = 0, `pix_data` = 0, `sq_x` = 0, and no mode advance at the next `eof`.

Source files
------------

// File: rtl/vga_pic_pkg.sv
// vga_pic_pkg -- shared constants for the VGA test-pattern source.
//   Mode encoding (MODE_BARS / MODE_SQUARE / MODE_GRAD), RGB444 colour
//   constants, the no-request coordinate, and the mode successor helper.
package vga_pic_pkg;

  localparam logic [9:0] NO_REQ = 10'h3FF;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_GRAD   = 2'd2
  } mode_e;

  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] YELLOW  = 12'hFF0;
  localparam logic [11:0] CYAN    = 12'h0FF;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] MAGENTA = 12'hF0F;
  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] BLACK   = 12'h000;

  // BARS -> SQUARE -> GRAD -> BARS; the unused encoding recovers to BARS.
  function automatic mode_e mode_succ(mode_e m);
    case (m)
      MODE_BARS:   return MODE_SQUARE;
      MODE_SQUARE: return MODE_GRAD;
      default:     return MODE_BARS;
    endcase
  endfunction

endpackage

// File: rtl/vga_pic_gen_if.sv
// vga_pic_gen_if -- request/response bundle between VGA timing controller
// (master) and pattern generator (slave).
//   pix_x/pix_y : requested coordinate, 10'h3FF = no request
//   mode_next   : one-cycle pulse asking for the next pattern
//   pix_data    : registered RGB444 colour
//   mode        : active pattern
//   frame_tick  : pulse the cycle after the last active pixel request
interface vga_pic_gen_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        mode_next;
  logic [11:0] pix_data;
  logic [1:0]  mode;
  logic        frame_tick;

  modport master (output pix_x, pix_y, mode_next,
                  input  pix_data, mode, frame_tick);
  modport slave  (input  pix_x, pix_y, mode_next,
                  output pix_data, mode, frame_tick);
endinterface

// File: rtl/vga_square_mover.sv
// vga_square_mover -- position of the bouncing square.
//   vga_clk, sys_rst_n (sync, active low), eof : advance one frame step
//   sq_x, sq_y : top-left corner of the square
// Each axis moves SQ_STEP per frame; on reaching or passing a limit it
// clamps to that limit and reverses in the same update.
module vga_square_mover #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int SQ_SIZE = 40,
  parameter int SQ_STEP = 2
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       eof,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y
);

  localparam logic [10:0] X_MAX = 11'(H_VALID - SQ_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_VALID - SQ_SIZE);
  localparam logic [10:0] STEP  = 11'(SQ_STEP);

  typedef struct packed {
    logic       dir;   // 1 = increasing
    logic [9:0] pos;
  } axis_t;

  function automatic axis_t axis_step(logic [9:0] pos, logic dir, logic [10:0] lim);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] fwd;
    logic [10:0] bwd;
    p   = {1'b0, pos};
    fwd = p + STEP;
    bwd = p - STEP;
    if (dir) begin
      if (fwd >= lim) r = '{dir: 1'b0, pos: lim[9:0]};
      else            r = '{dir: 1'b1, pos: fwd[9:0]};
    end else begin
      if (p <= STEP)  r = '{dir: 1'b1, pos: 10'd0};
      else            r = '{dir: 1'b0, pos: bwd[9:0]};
    end
    return r;
  endfunction

  logic  dir_x, dir_y;
  axis_t nx, ny;

  always_comb begin
    nx = axis_step(sq_x, dir_x, X_MAX);
    ny = axis_step(sq_y, dir_y, Y_MAX);
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      sq_x  <= '0;
      sq_y  <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (eof) begin
      sq_x  <= nx.pos;
      dir_x <= nx.dir;
      sq_y  <= ny.pos;
      dir_y <= ny.dir;
    end
  end

endmodule

// File: rtl/vga_pic_gen.sv
// vga_pic_gen -- test-pattern pixel source for the VGA timing controller.
//   vga_clk   : pixel clock
//   sys_rst_n : synchronous active-low reset
//   bus       : vga_pic_gen_if.slave (pix_x/pix_y/mode_next in,
//               pix_data/mode/frame_tick out)
// Patterns: colour bars, bouncing square, gradient. Mode and square
// position only change on the edge sampling the last active pixel (eof),
// so a frame is always drawn with one pattern.
// Optional: define VGA_PIC_BORDER_EN to draw a white 1-px frame border
// over every pattern.
module vga_pic_gen
  import vga_pic_pkg::*;
#(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int SQ_SIZE = 40,
  parameter int SQ_STEP = 2
) (
  input logic         vga_clk,
  input logic         sys_rst_n,
  vga_pic_gen_if.slave bus
);

  localparam logic [9:0]  X_LAST  = 10'(H_VALID - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_VALID - 1);
  localparam logic [9:0]  BAR_W   = 10'(H_VALID / 8);
  localparam logic [10:0] SQ_SZ11 = 11'(SQ_SIZE);

  logic        req_vld, eof;
  logic [9:0]  sq_x, sq_y;
  logic [9:0]  bar_idx;
  logic        sq_hit;
  logic [11:0] colour;
  mode_e       mode_q;
  logic        pending;

  assign req_vld = (bus.pix_x != NO_REQ) && (bus.pix_y != NO_REQ);
  assign eof     = req_vld && (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);

  vga_square_mover #(
    .H_VALID (H_VALID),
    .V_VALID (V_VALID),
    .SQ_SIZE (SQ_SIZE),
    .SQ_STEP (SQ_STEP)
  ) u_mover (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .eof       (eof),
    .sq_x      (sq_x),
    .sq_y      (sq_y)
  );

  // Mode FSM. A request arriving on the eof cycle itself counts as pending.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      mode_q  <= MODE_BARS;
      pending <= 1'b0;
    end else if (eof) begin
      if (pending || bus.mode_next) mode_q <= mode_succ(mode_q);
      pending <= 1'b0;
    end else if (bus.mode_next) begin
      pending <= 1'b1;
    end
  end

  assign bar_idx = bus.pix_x / BAR_W;

  // 11-bit compares so sq+SQ_SIZE cannot wrap.
  assign sq_hit = ({1'b0, bus.pix_x} >= {1'b0, sq_x}) &&
                  ({1'b0, bus.pix_x} <  {1'b0, sq_x} + SQ_SZ11) &&
                  ({1'b0, bus.pix_y} >= {1'b0, sq_y}) &&
                  ({1'b0, bus.pix_y} <  {1'b0, sq_y} + SQ_SZ11);

  always_comb begin
    colour = BLACK;
    case (mode_q)
      MODE_BARS: begin
        case (bar_idx)
          10'd0:   colour = WHITE;
          10'd1:   colour = YELLOW;
          10'd2:   colour = CYAN;
          10'd3:   colour = GREEN;
          10'd4:   colour = MAGENTA;
          10'd5:   colour = RED;
          10'd6:   colour = BLUE;
          default: colour = BLACK;
        endcase
      end
      MODE_SQUARE: colour = sq_hit ? RED : BLUE;
      MODE_GRAD:   colour = {bus.pix_x[9:6], bus.pix_y[8:5], 4'h0};
      default:     colour = BLACK;
    endcase
`ifdef VGA_PIC_BORDER_EN
    if (bus.pix_x == 10'd0 || bus.pix_x == X_LAST ||
        bus.pix_y == 10'd0 || bus.pix_y == Y_LAST)
      colour = WHITE;
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      bus.pix_data   <= BLACK;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.pix_data   <= req_vld ? colour : BLACK;
      bus.frame_tick <= eof;
    end
  end

  assign bus.mode = mode_q;

endmodule

// File: tb/tb_vga_pic_gen.sv
// tb_vga_pic_gen -- directed + randomized bench for vga_pic_gen against a
// frame-count based reference model (square position as a triangle wave).
module tb_vga_pic_gen;
  import vga_pic_pkg::*;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  vga_pic_gen_if vif();

  vga_pic_gen dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (vif)
  );

  always #20 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;

  // reference model state
  int m_mode   = 0;
  bit m_pend   = 0;
  int m_frames = 0;

  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Square travels SQ_STEP per frame and bounces between 0 and lim.
  function automatic int tri_pos(int n, int lim);
    int p;
    p = (n * 2) % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [11:0] ref_pix(int md, int x, int y, int fr);
    int sx, sy;
    logic [9:0] xv, yv;
    if (x == 1023 || y == 1023) return 12'h000;
`ifdef VGA_PIC_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
`endif
    xv = 10'(x);
    yv = 10'(y);
    case (md)
      0: return (x < 640) ? bars[x / 80] : 12'h000;
      1: begin
        sx = tri_pos(fr, 600);
        sy = tri_pos(fr, 440);
        return (x >= sx && x < sx + 40 && y >= sy && y < sy + 40) ? 12'hF00 : 12'h00F;
      end
      default: return {xv[9:6], yv[8:5], 4'h0};
    endcase
  endfunction

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive at negedge, check after the sampling edge.
  task automatic step(int x, int y, bit mn, string tag);
    logic [11:0] e_pix;
    bit vld, eof;
    @(negedge vga_clk);
    sys_rst_n     = 1'b1;
    vif.pix_x     = 10'(x);
    vif.pix_y     = 10'(y);
    vif.mode_next = mn;
    vld   = (x != 1023) && (y != 1023);
    eof   = vld && x == 639 && y == 479;
    e_pix = ref_pix(m_mode, x, y, m_frames);
    if (eof) begin
      m_frames++;
      if (m_pend || mn) m_mode = (m_mode + 1) % 3;
      m_pend = 0;
    end else if (mn) begin
      m_pend = 1;
    end
    @(posedge vga_clk);
    #1;
    if (vif.frame_tick === 1'b1) tick_cnt++;
    chk({tag, ".pix"},  vif.pix_data, e_pix);
    chk({tag, ".tick"}, {11'b0, vif.frame_tick}, {11'b0, eof});
    chk({tag, ".mode"}, {10'b0, vif.mode}, 12'(m_mode));
  endtask

  task automatic rst_step(bit mn);
    @(negedge vga_clk);
    sys_rst_n     = 1'b0;
    vif.pix_x     = 10'($urandom_range(0, 639));
    vif.pix_y     = 10'($urandom_range(0, 478));
    vif.mode_next = mn;
    m_mode = 0; m_pend = 0; m_frames = 0;
    @(posedge vga_clk);
    #1;
    chk("rst.pix",  vif.pix_data, 12'h000);
    chk("rst.tick", {11'b0, vif.frame_tick}, 12'h000);
    chk("rst.mode", {10'b0, vif.mode}, 12'h000);
  endtask

  // Random non-eof request, occasionally idle.
  task automatic rnd_step(bit mn, string tag);
    int x, y;
    x = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 639));
    y = int'($urandom_range(0, 478));
    step(x, y, mn, tag);
  endtask

  task automatic sq_probe(string tag);
    int sx, sy;
    sx = tri_pos(m_frames, 600);
    sy = tri_pos(m_frames, 440);
    step(sx, sy, 0, {tag, ".tl"});
    step(sx + 39, sy, 0, {tag, ".tr"});
    if (sx + 40 < 640) step(sx + 40, sy, 0, {tag, ".right"});
    if (sx > 0)        step(sx - 1, sy, 0, {tag, ".left"});
    if (sy + 40 < 480) step(sx, sy + 40, 0, {tag, ".below"});
    if (sy > 0)        step(sx, sy - 1, 0, {tag, ".above"});
    repeat (8) rnd_step(0, {tag, ".rnd"});
  endtask

  initial begin
    vif.pix_x     = 10'h3FF;
    vif.pix_y     = 10'h3FF;
    vif.mode_next = 1'b0;

    rst_step(0);
    rst_step(1);  // mode_next during reset must not leave anything pending

    // colour bars
    step(0, 0, 0, "bars0");
    step(80, 0, 0, "bars1");
    step(639, 479, 0, "bars_eof");
    step(1023, 10, 0, "idle");
    repeat (40) rnd_step(0, "bars_rnd");

    // exactly one frame_tick per frame
    tick_cnt = 0;
    repeat (200) rnd_step(0, "frm");
    step(639, 479, 0, "frm_eof");
    repeat (20) step(1023, 1023, 0, "frm_idle");
    chk("frame_tick_count", 12'(tick_cnt), 12'd1);

    // mode changes only at eof; multiple pulses give one step
    rnd_step(1, "mn_mid");
    repeat (10) rnd_step(0, "mn_wait");
    step(639, 479, 0, "mn_eof");
    rnd_step(1, "mn3a"); rnd_step(0, "mn3");
    rnd_step(1, "mn3b"); rnd_step(0, "mn3");
    rnd_step(1, "mn3c");
    step(639, 479, 0, "mn3_eof");
    step(639, 479, 1, "mn_coinc");   // GRAD -> BARS on this edge
    step(639, 479, 1, "mn_coinc2");  // BARS -> SQUARE

    // bouncing square
    sq_probe("sq_start");
    while (m_frames < 220) step(639, 479, 0, "adv");
    sq_probe("sq_y440");
    while (m_frames < 300) step(639, 479, 0, "adv");
    sq_probe("sq_x600");
    step(639, 479, 0, "adv");
    sq_probe("sq_x598");

    // gradient
    step(639, 479, 1, "to_grad");
    step(64, 32, 0, "grad_64_32");
    step(639, 479, 0, "grad_eof");
    repeat (20) rnd_step(0, "grad_rnd");

    // reset mid-frame with a pending change and the square moved away
    rst_step(0);
    while (m_frames < 50) step(639, 479, 0, "adv50");
    rnd_step(1, "pend_set");
    rnd_step(0, "pend_hold");
    rst_step(0);
    repeat (5) rnd_step(0, "post_rst");
    step(639, 479, 0, "post_rst_eof");  // must stay BARS
    step(639, 479, 1, "post_rst_sq");
    sq_probe("sq_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
